// File: rtl/nmr_acq_pkg.sv
// Shared types and sizes for the NMR acquisition packer.
package nmr_acq_pkg;

    localparam int unsigned SMP_W      = 32;
    localparam int unsigned WORD_W     = 64;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] dat;
    } word_t;

endpackage

// File: rtl/nmr_word_fifo.sv
// nmr_word_fifo: small synchronous FIFO with full/empty flags and a synchronous clear.
// Latency: a pushed entry is visible on o_dat the cycle after the push when the FIFO was empty.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module nmr_word_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nmr_acq_packer.sv
// nmr_acq_packer: pairs 32-bit ADC samples into 64-bit words for the RAM writer (NMR_PACKER_TEST_PATTERN_EN swaps samples for a count pattern).
// Latency: arm acts two cycles after acq_en_i rises; a word reaches m_axis one cycle after its pair completes.
// Backpressure: the ADC never stalls; a push into the full 4-deep FIFO drops the word and sets overflow_o.
module nmr_acq_packer
    import nmr_acq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acq_en_i,
    input  logic [31:0] nb_of_sample_i,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        done_o,
    output logic        overflow_o,
    output logic [31:0] count_o
);
    state_t             r_state;
    logic               r_en_q;
    logic               r_en_d;
    logic [31:0]        r_n;
    logic [31:0]        r_count;
    logic               r_ovf;
    logic [SMP_W-1:0]   r_pair;
    logic               r_half;

    logic               w_arm;
    logic               w_abort;
    logic               w_acc;
    logic               w_final;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [SMP_W-1:0]   w_smp;
    word_t              w_word;
    word_t              w_head;

`ifdef NMR_PACKER_TEST_PATTERN_EN
    assign w_smp = {~r_count[15:0], r_count[15:0]};
`else
    assign w_smp = s_axis_tdata;
`endif

    // Enable history resets high so a level already asserted at reset release is not an edge.
    assign w_arm   = r_en_q && !r_en_d && (r_state == ST_IDLE);
    assign w_abort = !acq_en_i && ((r_state == ST_CAPTURE) || (r_state == ST_FLUSH));
    assign w_acc   = acq_en_i && s_axis_tvalid && (r_state == ST_CAPTURE);
    assign w_final = w_acc && (r_count == r_n - 32'd1);
    assign w_push  = w_acc && (r_half || w_final);

    assign w_word.last = w_final;
    assign w_word.dat  = r_half ? {w_smp, r_pair} : {{SMP_W{1'b0}}, w_smp};

    nmr_word_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_arm || w_abort),
        .i_push  (w_push),
        .i_dat   (w_word),
        .i_pop   (m_axis_tready),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_head.dat;
    assign m_axis_tlast  = w_head.last;
    assign done_o        = (r_state == ST_DONE);
    assign overflow_o    = r_ovf;
    assign count_o       = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_en_q  <= 1'b1;
            r_en_d  <= 1'b1;
            r_n     <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_pair  <= '0;
            r_half  <= 1'b0;
        end else begin
            r_en_q <= acq_en_i;
            r_en_d <= r_en_q;
            case (r_state)
                ST_IDLE: begin
                    if (w_arm) begin
                        r_n     <= nb_of_sample_i;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_pair  <= '0;
                        r_half  <= 1'b0;
                        r_state <= (nb_of_sample_i == 32'd0) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_acc) begin
                        r_count <= r_count + 32'd1;
                        if (w_push) begin
                            r_half <= 1'b0;
                        end else begin
                            r_pair <= w_smp;
                            r_half <= 1'b1;
                        end
                        if (w_push && w_full) begin
                            r_ovf <= 1'b1;
                        end
                        // A dropped tlast word can never handshake, so skip FLUSH.
                        if (w_final) begin
                            r_state <= w_full ? ST_DONE : ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!acq_en_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmr_acq_packer.sv
// Bench for nmr_acq_packer: table-driven and random captures against a queue-based model, plus directed corner sequences.
module tb_nmr_acq_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        acq_en = 1'b0;
    logic [31:0] nb = 32'd0;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic        done;
    logic        ovf;
    logic [31:0] cnt;

    int          checks = 0;
    int          errors = 0;
    logic [64:0] rx_q[$];
    bit          seen_vld = 1'b0;
    bit          prev_stall = 1'b0;
    logic [64:0] prev_word = '0;

    typedef struct {
        int n;
        int vld_pct;
        int exp_words;
        int exp_cnt;
    } vec_t;

    vec_t vecs[6];

    nmr_acq_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .acq_en_i       (acq_en),
        .nb_of_sample_i (nb),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .done_o         (done),
        .overflow_o     (ovf),
        .count_o        (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Value the DUT should store for the idx-th accepted sample (idx counts from 0).
    function automatic logic [31:0] smp_model(input int idx, input logic [31:0] raw);
        logic [31:0] v;
`ifdef NMR_PACKER_TEST_PATTERN_EN
        v = idx;
        v = {~v[15:0], v[15:0]};
`else
        v = raw;
`endif
        return v;
    endfunction

    // Handshake recorder and AXI-Stream stability watcher.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", {64'd0, m_tvalid}, 65'd1);
                chk("stall_word", {m_tlast, m_tdata}, prev_word);
            end
            if (m_tvalid) seen_vld = 1'b1;
            if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
            prev_stall = m_tvalid && !m_tready;
            prev_word  = {m_tlast, m_tdata};
        end
    end

    task automatic run_capture(input int n, input int vld_pct, input bit rdy_rand, input string tag);
        logic [31:0] smp[$];
        logic [64:0] exp_w[$];
        logic [31:0] hi;
        int          budget;
        bit          rdy_low;
        rx_q.delete();
        rdy_low  = 1'b0;
        nb       = n;
        m_tready = 1'b1;
        acq_en   = 1'b1;
        step();
        step();
        budget = 0;
        while (smp.size() < n && budget < 2000) begin
            s_tvalid = ($urandom_range(99) < vld_pct);
            s_tdata  = $urandom;
            if (s_tvalid) smp.push_back(smp_model(smp.size(), s_tdata));
            rdy_low  = rdy_rand && !rdy_low && ($urandom_range(1) == 0);
            m_tready = !rdy_low;
            step();
            budget++;
        end
        s_tvalid = 1'b0;
        budget = 0;
        while (!done && budget < 200) begin
            rdy_low  = rdy_rand && !rdy_low && ($urandom_range(1) == 0);
            m_tready = !rdy_low;
            step();
            budget++;
        end
        m_tready = 1'b1;
        for (int i = 0; i < n; i += 2) begin
            hi = (i + 1 < n) ? smp[i+1] : 32'h0;
            exp_w.push_back({(i + 2 >= n), hi, smp[i]});
        end
        chk({tag, "_done"}, {64'd0, done}, 65'd1);
        chk({tag, "_count"}, {33'd0, cnt}, 65'(n));
        chk({tag, "_ovf"}, {64'd0, ovf}, 65'd0);
        chk({tag, "_nwords"}, 65'(rx_q.size()), 65'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) begin
            if (i < rx_q.size()) chk($sformatf("%s_word%0d", tag, i), rx_q[i], exp_w[i]);
        end
        acq_en = 1'b0;
        step();
        chk({tag, "_idle_done"}, {64'd0, done}, 65'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] s[$];
        logic [31:0] tmp;

        // Reset state before any clock edge.
        #1;
        chk("rst_tvalid", {64'd0, m_tvalid}, 65'd0);
        chk("rst_tlast", {64'd0, m_tlast}, 65'd0);
        chk("rst_tdata", {1'b0, m_tdata}, 65'd0);
        chk("rst_done", {64'd0, done}, 65'd0);
        chk("rst_ovf", {64'd0, ovf}, 65'd0);
        chk("rst_count", {33'd0, cnt}, 65'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        // N=4, continuous samples, tready high: content and done timing.
        rx_q.delete();
        s.delete();
        nb = 4; m_tready = 1'b1; acq_en = 1'b1;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s.push_back(smp_model(i, s_tdata));
            step();
        end
        s_tvalid = 1'b0;
        chk("n4_last_vld", {63'd0, m_tvalid, m_tlast}, 65'd3);
        chk("n4_last_dat", {1'b0, m_tdata}, {1'b0, s[3], s[2]});
        chk("n4_done_early", {64'd0, done}, 65'd0);
        step();
        chk("n4_done", {64'd0, done}, 65'd1);
        chk("n4_nwords", 65'(rx_q.size()), 65'd2);
        if (rx_q.size() >= 2) begin
            chk("n4_w0", rx_q[0], {1'b0, s[1], s[0]});
            chk("n4_w1", rx_q[1], {1'b1, s[3], s[2]});
        end
        acq_en = 1'b0;
        step();

        // N=0: straight to DONE, no words.
        seen_vld = 1'b0;
        nb = 0; acq_en = 1'b1;
        step();
        chk("n0_done_c1", {64'd0, done}, 65'd0);
        step();
        chk("n0_done_c2", {64'd0, done}, 65'd1);
        step();
        step();
        chk("n0_no_vld", {64'd0, seen_vld}, 65'd0);
        acq_en = 1'b0;
        step();

        // Table of captures with tready held high.
        vecs[0] = '{4, 100, 2, 4};
        vecs[1] = '{3, 100, 2, 3};
        vecs[2] = '{1, 100, 1, 1};
        vecs[3] = '{2, 50, 1, 2};
        vecs[4] = '{7, 70, 4, 7};
        vecs[5] = '{8, 40, 4, 8};
        for (int v = 0; v < 6; v++) begin
            run_capture(vecs[v].n, vecs[v].vld_pct, 1'b0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_tbl_words", v), 65'(rx_q.size()), 65'(vecs[v].exp_words));
            chk($sformatf("vec%0d_tbl_cnt", v), {33'd0, cnt}, 65'(vecs[v].exp_cnt));
        end

        // N=20 with tready low: FIFO fills, 5th push overflows, dropped tlast ends the run.
        rx_q.delete();
        s.delete();
        nb = 20; m_tready = 1'b0; acq_en = 1'b1;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s.push_back(smp_model(i, s_tdata));
            step();
            if (i == 7) chk("ovf_before", {64'd0, ovf}, 65'd0);
            if (i == 9) chk("ovf_5th_push", {64'd0, ovf}, 65'd1);
        end
        s_tvalid = 1'b0;
        chk("ovf_done", {64'd0, done}, 65'd1);
        chk("ovf_count", {33'd0, cnt}, 65'd20);
        step();
        step();
        chk("ovf_head", {m_tvalid, m_tlast, m_tdata[62:0]}, {1'b1, 1'b0, s[1][30:0], s[0]});
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("ovf_nwords", 65'(rx_q.size()), 65'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) chk($sformatf("ovf_w%0d", i), rx_q[i], {1'b0, s[2*i+1], s[2*i]});
        end
        chk("ovf_drained", {64'd0, m_tvalid}, 65'd0);
        acq_en = 1'b0;
        step();
        chk("ovf_sticky_idle", {64'd0, ovf}, 65'd1);
        chk("ovf_idle_done", {64'd0, done}, 65'd0);

        // N=100 aborted after 10 samples, then a clean re-arm.
        nb = 100; m_tready = 1'b1; acq_en = 1'b1;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            step();
        end
        s_tvalid = 1'b0;
        acq_en = 1'b0;
        step();
        chk("abort_vld", {64'd0, m_tvalid}, 65'd0);
        chk("abort_done", {64'd0, done}, 65'd0);
        chk("abort_count", {33'd0, cnt}, 65'd10);
        step();
        chk("abort_empty", {64'd0, m_tvalid}, 65'd0);
        run_capture(6, 100, 1'b0, "rearm");

        // Asynchronous reset mid-capture, released with acq_en_i still high.
        nb = 50; m_tready = 1'b0; acq_en = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom | 32'h1;
            step();
        end
        s_tvalid = 1'b0;
        chk("pre_rst_count", {33'd0, cnt}, 65'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", {64'd0, m_tvalid}, 65'd0);
        chk("arst_tlast", {64'd0, m_tlast}, 65'd0);
        chk("arst_tdata", {1'b0, m_tdata}, 65'd0);
        chk("arst_done", {64'd0, done}, 65'd0);
        chk("arst_ovf", {64'd0, ovf}, 65'd0);
        chk("arst_count", {33'd0, cnt}, 65'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            tmp = $urandom;
            s_tdata = tmp;
            step();
        end
        s_tvalid = 1'b0;
        chk("hi_at_release_count", {33'd0, cnt}, 65'd0);
        chk("hi_at_release_vld", {64'd0, m_tvalid}, 65'd0);
        chk("hi_at_release_done", {64'd0, done}, 65'd0);
        acq_en = 1'b0;
        step();
        step();

        // Random captures with sparse samples and intermittent backpressure.
        for (int r = 0; r < 8; r++) begin
            run_capture($urandom_range(1, 24), $urandom_range(30, 100), 1'b1, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmr_acq_packer.md
NMR_ACQ_PACKER -- requirements
Module: nmr_acq_packer

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all logic rising-edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: acq_en_i  input  1  capture window enable from the acquisition sequencer; rising edge arms the block.
REQ-004 SHALL have port: nb_of_sample_i  input  32  number of ADC samples to capture, latched on the acq_en_i rising edge.
REQ-005 SHALL have port: s_axis_tdata  input  32  ADC sample, ch A [15:0], ch B [31:16].
REQ-006 SHALL have port: s_axis_tvalid  input  1  sample strobe; no ready, because the ADC cannot stall.
REQ-007 SHALL have ports: m_axis_tdata output 64, m_axis_tvalid output 1, m_axis_tlast output 1, m_axis_tready input 1; packed words to the RAM writer.
REQ-008 SHALL have ports: done_o output 1, overflow_o output 1, count_o output 32 (samples accepted in the current run).

Function
REQ-009 SHALL implement the states IDLE, CAPTURE, FLUSH and DONE.
REQ-010 SHALL go from IDLE to CAPTURE on an acq_en_i 0->1 edge, and SHALL latch nb_of_sample_i, clear count_o, clear overflow_o and clear the FIFO in that cycle.
REQ-011 SHALL go from IDLE straight to DONE on that edge if the latched count is 0, and SHALL emit no words.
REQ-012 SHALL, in CAPTURE, accept a sample on every cycle where s_axis_tvalid=1 and increment count_o by 1 per accepted sample.
REQ-013 SHALL pack the first sample of each pair into tdata[31:0] and the second into tdata[63:32].
REQ-014 SHALL push a word into the output FIFO in the same cycle the pair completes.
REQ-015 SHALL make the pushed word visible on m_axis one cycle after that push, when the FIFO was empty.
REQ-016 SHALL, when the final sample is accepted (count reaches the latched N), push the final word with its tlast flag set.
REQ-017 SHALL zero the tdata[63:32] half of the final word if N is odd.
REQ-018 SHALL go to FLUSH after the final sample is accepted, and SHALL ignore s_axis_tvalid in FLUSH.
REQ-019 SHALL go from FLUSH to DONE when the final word (tlast=1) completes its handshake.
REQ-020 SHALL follow AXI-Stream rules on m_axis: tdata, tvalid and tlast stay stable while tvalid=1 and tready=0.
REQ-021 SHALL, on an attempted FIFO push while the FIFO is full, drop the word and set overflow_o sticky until the next arm.
REQ-022 SHALL keep counting on an overflow; if the dropped word carried tlast, it SHALL go straight to DONE.
REQ-023 SHALL hold done_o=1 in DONE and SHALL return to IDLE, clearing done_o, when acq_en_i=0.
REQ-024 SHALL, if acq_en_i falls in CAPTURE or FLUSH, abort: go to IDLE next cycle, flush the FIFO, drop m_axis_tvalid, leave done_o=0, and keep count_o and overflow_o.
REQ-025 SHALL treat the latched count as unsigned 32-bit; count_o SHALL never exceed it.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force: state=IDLE, FIFO empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, done_o=0, overflow_o=0, count_o=0, pair register cleared.
REQ-027 SHALL treat an acq_en_i level that is already high at reset release as not armed; only a later 0->1 edge arms the block.

Configuration
REQ-028 SHALL, with NMR_PACKER_TEST_PATTERN_EN defined, replace each accepted sample with {count[15:0] inverted, count[15:0]}, where count is the value before increment; timing is unchanged.
REQ-029 SHALL, without the macro, pass s_axis_tdata unmodified, and the pattern logic SHALL be absent.

Structure
REQ-030 SHALL place in the shared package nmr_acq_pkg: the state enum, sample width (32), word width (64) and FIFO depth (4).
REQ-031 SHALL instantiate one sub-module, nmr_word_fifo: synchronous FIFO, 65 bits wide (data + last), depth 4, with full and empty flags and a synchronous clear.

Verification
REQ-032 SHALL check: N=4, continuous tvalid, tready=1 -> 2 words, {S1,S0} then {S3,S2}; tlast on word 2; done_o=1 one cycle after that handshake.
REQ-033 SHALL check: N=3 -> word 2 = {32'h0,S2} with tlast=1; count_o=3.
REQ-034 SHALL check: N=0 -> done_o=1 two cycles after the arm edge; m_axis_tvalid never asserted.
REQ-035 SHALL check: N=20, tready=0 throughout -> 4 words held stable; overflow_o=1 on the 5th push; done_o=1; count_o=20.
REQ-036 SHALL check: N=100, acq_en_i dropped after 10 samples -> IDLE, FIFO empty, done_o=0, count_o=10; a re-arm then runs cleanly.
REQ-037 SHALL check: rst_n pulsed low mid-CAPTURE -> all outputs zero immediately, without waiting for a clock edge.
